gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- N-bit up/down counter that produces a registered Gray-coded value for the downstream Gray-to-binary converter stage.
- A matching registered binary count is also output, so the pair can be cross-checked.
- Supports synchronous load of a binary value.
- Supports wrap or saturate at the count limits, and provides limit flags and a one-cycle wrap pulse.

Parameters:
- N, 4, counter width in bits (N >= 2).
- WRAP, 1:
  - 1 = count wraps modulo 2^N.
  - 0 = count saturates at all-ones (up) and at zero (down).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_value  input  N  binary value to load.
- gray_value  output  N  registered Gray code of binary_count.
- binary_count  output  N  registered binary count.
- wrap  output  1  registered one-cycle pulse on a wrap event.
- at_max  output  1  binary_count == 2^N-1; decoded from the register.
- at_min  output  1  binary_count == 0; decoded from the register.

Behaviour:
- Reset, rst=1 at a rising edge:
  - binary_count=0, gray_value=0, wrap=0.
  - Hence at_min=1, at_max=0.
  - rst overrides load and en in the same cycle.
  - Reset mid-count discards the count; counting resumes from 0 in the first cycle after rst deasserts.
- Priority per cycle: rst > load > en > hold.
- Load (load=1):
  - binary_count <= load_value.
  - gray_value <= load_value ^ (load_value >> 1).
  - wrap <= 0; en and up_dn are ignored.
- Count (en=1, load=0, up_dn=1):
  - If binary_count != all-ones: count +1, wrap <= 0.
  - If all-ones and WRAP=1: count <= 0, wrap <= 1.
  - If all-ones and WRAP=0: count holds, wrap <= 0.
- Count (en=1, load=0, up_dn=0):
  - If binary_count != 0: count -1, wrap <= 0.
  - If 0 and WRAP=1: count <= all-ones, wrap <= 1.
  - If 0 and WRAP=0: count holds, wrap <= 0.
- Hold (en=0, load=0): count and gray_value unchanged; wrap <= 0.
- Latency: outputs reflect a step, load or reset one clock after the controlling edge.
- Invariants:
  - gray_value always equals binary_count ^ (binary_count >> 1) in every cycle.
  - The Gray and binary registers are updated together; there is no cycle of skew between them.
- Single-bit change: each ±1 step, including modulo wrap, changes exactly one bit of gray_value. A load or reset may change any number of bits.
- Arithmetic is N-bit unsigned; there is no carry or borrow output beyond wrap.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (e.g., N=2 alternating direction at a limit) produce consecutive pulses.

Test Plan:
- N=4, WRAP=1, rst then en=1, up_dn=1 for 17 cycles:
  - gray_value follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - wrap is high only on the 8->0 transition.
  - Exactly one gray bit toggles per step.
- N=4, WRAP=1, load=1, load_value=0 then down 2 steps:
  - binary_count goes 0 -> F -> E; gray_value goes 0 -> 8 -> 9.
  - wrap pulses once, on the 0->F step.
- N=4, WRAP=0, load_value=E, up for 3 cycles:
  - binary_count goes E, F, F, F; gray_value stays 8 once at F.
  - at_max=1 and wrap is never asserted.
  - Repeat down from 1: count 1, 0, 0 with at_min=1.
- Priority: load=1, load_value=5, with en=1 in the same cycle:
  - binary_count=5, gray_value=7 (no step applied).
  - rst=1 together with load=1: binary_count=0, gray_value=0.
- Reset mid-operation: count to 9, assert rst for one cycle, then resume up:
  - Outputs go 0 at the reset edge, then 1, 2, ...
  - wrap=0 throughout.
- Randomized en/up_dn/load for 2000 cycles, every cycle:
  - gray_value == binary_count ^ (binary_count >> 1).
  - The Gray output, fed into the downstream converter, matches binary_count delayed by one cycle.

Source files
------------

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - N-bit up/down counter with registered Gray and binary outputs
//
// Purpose:
//   Up/down counter whose binary count and Gray-coded image are held in
//   registers updated on the same edge, so the pair never skews. Supports a
//   synchronous binary load, wrap or saturate at the limits, limit flags and
//   a one-cycle wrap pulse.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   en           in   count enable, one step per cycle while high
//   up_dn        in   direction, 1 = increment, 0 = decrement
//   load         in   synchronous load strobe (beats en)
//   load_value   in   binary value to load
//   gray_value   out  registered Gray code of binary_count
//   binary_count out  registered binary count
//   wrap         out  registered one-cycle pulse on a wrap event
//   at_max       out  binary_count is all-ones
//   at_min       out  binary_count is zero

module gray_code_counter #(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] gray_value,
    output logic [N-1:0] binary_count,
    output logic         wrap,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_MIN = '0;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic [N-1:0] next_bin;
    logic         next_wrap;

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next-state selection: load > en > hold (reset handled in the register).
    always_comb begin
        next_bin  = binary_count;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_value;
        end else if (en) begin
            if (up_dn) begin
                if (binary_count != CNT_MAX) begin
                    next_bin = binary_count + CNT_ONE;
                end else if (WRAP) begin
                    next_bin  = CNT_MIN;
                    next_wrap = 1'b1;
                end
            end else begin
                if (binary_count != CNT_MIN) begin
                    next_bin = binary_count - CNT_ONE;
                end else if (WRAP) begin
                    next_bin  = CNT_MAX;
                    next_wrap = 1'b1;
                end
            end
        end
    end

    // Gray register is loaded from the same next value as the binary
    // register, which keeps the two in lock-step every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            binary_count <= '0;
            gray_value   <= '0;
            wrap         <= 1'b0;
        end else begin
            binary_count <= next_bin;
            gray_value   <= bin2gray(next_bin);
            wrap         <= next_wrap;
        end
    end

    assign at_max = (binary_count == CNT_MAX);
    assign at_min = (binary_count == CNT_MIN);

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - randomized and directed bench for gray_code_counter

module tb_gray_code_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] gray_w, bin_w, gray_s, bin_s;
    logic       wrap_w, max_w, min_w, wrap_s, max_s, min_s;

    int n_checks = 0;
    int n_errors = 0;

    // Expected Gray sequence for a 4-bit count, indexed by binary value.
    int gray_tab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    // Reference model state: index 0 = wrapping instance, 1 = saturating.
    int m_cnt[2];
    int m_wrap[2];

    always #5 clk = ~clk;

    gray_code_counter #(.N(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_value(load_value), .gray_value(gray_w), .binary_count(bin_w),
        .wrap(wrap_w), .at_max(max_w), .at_min(min_w)
    );

    gray_code_counter #(.N(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_value(load_value), .gray_value(gray_s), .binary_count(bin_s),
        .wrap(wrap_s), .at_max(max_s), .at_min(min_s)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input int lv, input bit e, input bit u);
        for (int i = 0; i < 2; i++) begin
            m_wrap[i] = 0;
            if (r) begin
                m_cnt[i] = 0;
            end else if (ld) begin
                m_cnt[i] = lv;
            end else if (e) begin
                if (u) begin
                    if (m_cnt[i] < 15)  m_cnt[i] = m_cnt[i] + 1;
                    else if (i == 0) begin m_cnt[i] = 0; m_wrap[i] = 1; end
                end else begin
                    if (m_cnt[i] > 0)   m_cnt[i] = m_cnt[i] - 1;
                    else if (i == 0) begin m_cnt[i] = 15; m_wrap[i] = 1; end
                end
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check_eq({ctx, " w.bin"},  int'(bin_w),  m_cnt[0]);
        check_eq({ctx, " w.gray"}, int'(gray_w), gray_tab[m_cnt[0]]);
        check_eq({ctx, " w.wrap"}, int'(wrap_w), m_wrap[0]);
        check_eq({ctx, " w.max"},  int'(max_w),  int'(m_cnt[0] == 15));
        check_eq({ctx, " w.min"},  int'(min_w),  int'(m_cnt[0] == 0));
        check_eq({ctx, " s.bin"},  int'(bin_s),  m_cnt[1]);
        check_eq({ctx, " s.gray"}, int'(gray_s), gray_tab[m_cnt[1]]);
        check_eq({ctx, " s.wrap"}, int'(wrap_s), m_wrap[1]);
        check_eq({ctx, " s.max"},  int'(max_s),  int'(m_cnt[1] == 15));
        check_eq({ctx, " s.min"},  int'(min_s),  int'(m_cnt[1] == 0));
    endtask

    // Drive one cycle of inputs, advance past the edge, update model, compare.
    task automatic step(input string ctx, input bit r, input bit ld, input int lv,
                        input bit e, input bit u);
        rst = r; load = ld; load_value = 4'(lv); en = e; up_dn = u;
        @(posedge clk);
        #1;
        model_step(r, ld, lv, e, u);
        compare_all(ctx);
    endtask

    initial begin
        logic [3:0] prev_gray;
        int         wrap_seen;

        m_cnt = '{0, 0};
        m_wrap = '{0, 0};

        // Reset state.
        step("reset", 1, 0, 0, 0, 0);
        check_eq("reset at_min", int'(min_w), 1);

        // Up count through the full wrapping sequence; one Gray bit per step.
        wrap_seen = 0;
        for (int k = 0; k < 17; k++) begin
            prev_gray = gray_w;
            step("up17", 0, 0, 0, 1, 1);
            check_eq("up17 gray bits toggled", $countones(gray_w ^ prev_gray), 1);
            wrap_seen += int'(wrap_w);
        end
        check_eq("up17 wrap count", wrap_seen, 1);

        // Load 0, then down twice: wraps to F then E.
        step("load0", 0, 1, 0, 0, 0);
        step("dn1", 0, 0, 0, 1, 0);
        check_eq("dn1 gray", int'(gray_w), 8);
        step("dn2", 0, 0, 0, 1, 0);
        check_eq("dn2 gray", int'(gray_w), 9);

        // Saturation at the top and bottom.
        step("loadE", 0, 1, 14, 0, 0);
        for (int k = 0; k < 3; k++) step("sat_up", 0, 0, 0, 1, 1);
        check_eq("sat_up s.bin", int'(bin_s), 15);
        step("load1", 0, 1, 1, 0, 0);
        for (int k = 0; k < 2; k++) step("sat_dn", 0, 0, 0, 1, 0);
        check_eq("sat_dn s.bin", int'(bin_s), 0);

        // Priority: load beats en, rst beats load.
        step("load5_en", 0, 1, 5, 1, 1);
        check_eq("load5 gray", int'(gray_w), 7);
        step("rst_load", 1, 1, 9, 1, 1);

        // Hold with en low.
        step("hold", 0, 0, 0, 0, 1);

        // Reset mid-count, then resume.
        for (int k = 0; k < 9; k++) step("to9", 0, 0, 0, 1, 1);
        check_eq("to9 bin", int'(bin_w), 9);
        step("mid_rst", 1, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) step("resume", 0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            step("rand", ($urandom_range(63) == 0), ($urandom_range(7) == 0),
                 int'($urandom_range(15)), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
